// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store memory master: access sizes, FSM states,
// lane widths and the misalignment predicate.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts and extends load data from a RAM word,
// and merges right-aligned store data into the previously read word.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [1:0]           size_i,
    input  logic [1:0]           addr_lo_i,
    input  logic                 unsigned_i,
    input  logic [BUS_WIDTH-1:0] rdata_i,
    input  logic [BUS_WIDTH-1:0] wdata_i,
    output logic [BUS_WIDTH-1:0] load_data_o,
    output logic [BUS_WIDTH-1:0] store_data_o
);

    logic [BYTE_W-1:0] byte_s;
    logic [HALF_W-1:0] half_s;
    logic              byte_sgn_s;
    logic              half_sgn_s;

    // Load path: select the addressed lane and replicate its sign unless unsigned.
    always_comb begin
        byte_s      = rdata_i[{addr_lo_i, 3'b000} +: BYTE_W];
        half_s      = rdata_i[{addr_lo_i[1], 4'b0000} +: HALF_W];
        byte_sgn_s  = ~unsigned_i & byte_s[BYTE_W-1];
        half_sgn_s  = ~unsigned_i & half_s[HALF_W-1];
        load_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: load_data_o = {{(BUS_WIDTH-BYTE_W){byte_sgn_s}}, byte_s};
            SZ_HALF: load_data_o = {{(BUS_WIDTH-HALF_W){half_sgn_s}}, half_s};
            default: load_data_o = rdata_i;
        endcase
    end

    // Store path: overwrite only the addressed lane(s), keep the other bytes.
    always_comb begin
        store_data_o = rdata_i;
        case (size_i)
            SZ_BYTE: store_data_o[{addr_lo_i, 3'b000} +: BYTE_W]    = wdata_i[BYTE_W-1:0];
            SZ_HALF: store_data_o[{addr_lo_i[1], 4'b0000} +: HALF_W] = wdata_i[HALF_W-1:0];
            default: store_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the word-indexed data RAM; sub-word stores use read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return resp_error.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [BUS_WIDTH-1:0] req_addr,
    input  logic [BUS_WIDTH-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [BUS_WIDTH-1:0] resp_rdata,
    output logic                 resp_error,
    input  logic                 mem_ready,
    output logic                 mem_write_en,
    output logic [BUS_WIDTH-1:0] mem_addr_write,
    output logic [BUS_WIDTH-1:0] mem_data_write,
    output logic [BUS_WIDTH-1:0] mem_addr_read,
    input  logic [BUS_WIDTH-1:0] mem_data_read
);

    lsu_state_e           state_q, state_d;
    logic                 run_q;
    logic                 write_q, write_d;
    logic [1:0]           size_q, size_d;
    logic                 unsigned_q, unsigned_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 accept_s;
    logic                 trap_s;
    logic                 word_store_s;
    logic [BUS_WIDTH-1:0] word_idx_s;
    logic [BUS_WIDTH-1:0] load_data_s;
    logic [BUS_WIDTH-1:0] store_data_s;

    lsu_lane_align #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_align (
        .size_i       (size_q),
        .addr_lo_i    (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .rdata_i      (rdata_q),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_s),
        .store_data_o (store_data_s)
    );

    // State and request registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; READ/WRITE stall in place while the RAM is not ready.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        accept_s     = req_valid & req_ready;
        word_store_s = req_write & req_size[1];
`ifdef LSU_MISALIGN_TRAP_EN
        trap_s       = is_misaligned(req_size, req_addr[1:0]);
`else
        trap_s       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    err_d      = trap_s;
                    if (trap_s) begin
                        state_d = ST_RESP;
                    end else if (word_store_s) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (mem_ready) begin
                    rdata_d = mem_data_read;
                    state_d = write_q ? ST_WRITE : ST_RESP;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; all zero in IDLE and while in reset.
    always_comb begin
        word_idx_s     = {2'b00, addr_q[BUS_WIDTH-1:2]};
        req_ready      = run_q & (state_q == ST_IDLE) & mem_ready;
        mem_addr_read  = '0;
        mem_addr_write = '0;
        mem_write_en   = 1'b0;
        mem_data_write = '0;
        resp_valid     = 1'b0;
        resp_rdata     = '0;
        resp_error     = 1'b0;
        if (state_q != ST_IDLE) begin
            mem_addr_read  = word_idx_s;
            mem_addr_write = word_idx_s;
        end else begin
            mem_addr_read  = '0;
            mem_addr_write = '0;
        end
        case (state_q)
            ST_WRITE: begin
                mem_write_en   = mem_ready;
                mem_data_write = store_data_s;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (write_q | err_q) ? '0 : load_data_s;
            end
            default: begin
                mem_write_en = 1'b0;
                resp_valid   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a behavioural word RAM
// and an expected-response scoreboard queue.
module tb_lsu_mem_master;

    logic        clk;
    logic        nreset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_ready;
    logic        mem_write_en;
    logic [31:0] mem_addr_write;
    logic [31:0] mem_data_write;
    logic [31:0] mem_addr_read;
    logic [31:0] mem_data_read;

    logic [31:0] ram [0:63];
    logic        ram_clr;
    int          wr_cnt   = 0;
    int          resp_cnt = 0;
    int          checks   = 0;
    int          errors   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] err;
        int          lat;
        int          wr;
    } exp_t;
    exp_t sb[$];

    lsu_mem_master #(.BUS_WIDTH(32)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_error     (resp_error),
        .mem_ready      (mem_ready),
        .mem_write_en   (mem_write_en),
        .mem_addr_write (mem_addr_write),
        .mem_data_write (mem_data_write),
        .mem_addr_read  (mem_addr_read),
        .mem_data_read  (mem_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_read = (mem_addr_read < 32'd64) ? ram[mem_addr_read[5:0]] : 32'd0;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'd0;
        end else if (mem_write_en && (mem_addr_write < 32'd64)) begin
            ram[mem_addr_write[5:0]] <= mem_data_write;
        end
        if (mem_write_en) wr_cnt <= wr_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_wr);
        exp_t e;
        int   cyc;
        int   wr0;
        int   seen;
        e.rdata = exp_rdata;
        e.err   = {31'd0, exp_err};
        e.lat   = exp_lat;
        e.wr    = exp_wr;
        sb.push_back(e);
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1;
                break;
            end
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, (seen != 0) ? cyc : -1, e.lat);
        chk({tag, "_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_err"}, {31'd0, resp_error}, e.err);
        @(posedge clk);
        #1 chk({tag, "_writes"}, wr_cnt - wr0, e.wr);
    endtask

    initial begin
        int wr0;
        int rc0;
        int cyc;
        nreset       = 1'b0;
        ram_clr      = 1'b1;
        mem_ready    = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;

        // Reset state
        #1 chk("rst_outputs", {31'd0, |{req_ready, resp_valid, resp_rdata, resp_error, mem_write_en,
                                        mem_addr_write, mem_data_write, mem_addr_read}}, 32'd0);
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        nreset  = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        mem_ready = 1'b0;
        #1 chk("ready_follows_mem", {31'd0, req_ready}, 32'd0);
        mem_ready = 1'b1;

        // Word store, sub-word store, loads
        do_req("st_word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1);
        chk("ram4_word", ram[4], 32'hDEADBEEF);
        do_req("st_byte", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3, 1);
        chk("ram4_byte", ram[4], 32'hDEADAAEF);
        do_req("ld_b_s", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0);
        do_req("ld_b_u", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000AA, 1'b0, 2, 0);
        do_req("ld_h_s", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0);
        do_req("ld_h_u", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0, 2, 0);
        do_req("ld_b0_s", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 0);
        do_req("ld_h0_s", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFFAAEF, 1'b0, 2, 0);

        // Misaligned accesses
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("ld_w_mis", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0);
`else
        do_req("ld_w_mis", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'hDEADAAEF, 1'b0, 2, 0);
`endif
        do_req("st_w12", 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, 32'h0, 1'b0, 2, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("st_h_mis", 1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFF5555, 32'h0, 1'b1, 1, 0);
        chk("ram12_mis", ram[12], 32'h11223344);
`else
        do_req("st_h_mis", 1'b1, 2'b01, 1'b0, 32'h31, 32'hFFFF5555, 32'h0, 1'b0, 3, 1);
        chk("ram12_mis", ram[12], 32'h11225555);
`endif

        // Upper half store then size 2'b11 load (treated as word)
        do_req("st_h_hi", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, 32'h0, 1'b0, 3, 1);
        do_req("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hBEEFAAEF, 1'b0, 2, 0);

        // RAM stall during WRITE
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        mem_ready = 1'b0;
        #1 chk("stall_we_low", {31'd0, mem_write_en}, 32'd0);
        chk("stall_addr", mem_addr_write, 32'd8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_no_we", {31'd0, mem_write_en | resp_valid}, 32'd0);
        end
        chk("stall_ram", ram[8], 32'd0);
        mem_ready = 1'b1;
        #1 chk("stall_resume_we", {31'd0, mem_write_en}, 32'd1);
        cyc = 0;
        while (!resp_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("stall_resp", {31'd0, resp_valid}, 32'd1);
        chk("stall_ram_done", ram[8], 32'h12345678);
        chk("stall_writes", wr_cnt - wr0, 32'd1);

        // Reset in the middle of WRITE
        @(negedge clk);
        req_addr = 32'h24; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        wr0 = wr_cnt;
        rc0 = resp_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rstw_in_write", {31'd0, mem_write_en}, 32'd1);
        nreset = 1'b0;
        #1 chk("rstw_outputs", {31'd0, |{req_ready, resp_valid, resp_rdata, resp_error, mem_write_en,
                                         mem_addr_write, mem_data_write, mem_addr_read}}, 32'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rstw_no_resp", resp_cnt - rc0, 32'd0);
        chk("rstw_no_write", wr_cnt - wr0, 32'd0);
        chk("rstw_ram", ram[9], 32'd0);
        chk("rstw_ready", {31'd0, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
